// File: rtl/mem_controller.sv
// Byte-serial memory controller arbitrating instruction fetch and load/store unit.
// Optional MC_IO_STALL_EN holds LSB writes to the I/O window while the UART buffer is full.
module mem_controller #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter logic [1:0]  IO_PREFIX  = 2'b11
) (
  input  logic                  Sys_clk,
  input  logic                  Sys_rst,
  input  logic                  Sys_rdy,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_wr,
  input  logic                  io_buffer_full,
  input  logic                  IFMC_en,
  input  logic [31:0]           IFMC_addr,
  output logic                  MCIF_en,
  output logic [31:0]           MCIF_data,
  input  logic                  LSBMC_en,
  input  logic                  LSBMC_wr,
  input  logic [2:0]            LSBMC_data_width,
  input  logic [31:0]           LSBMC_data,
  input  logic [31:0]           LSBMC_addr,
  output logic                  MCLSB_r_en,
  output logic                  MCLSB_w_en,
  output logic [31:0]           MCLSB_data,
  input  logic                  RoBMC_pre_judge
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t                state, state_n;
  logic [1:0]            k, k_n;
  logic [1:0]            last, last_n;
  logic                  is_lsb, is_lsb_n;
  logic [ADDR_WIDTH-1:0] base, base_n;
  logic [31:0]           wshift, wshift_n;
  logic [31:0]           rbuf, rbuf_n;
  logic [ADDR_WIDTH-1:0] mem_a_n;
  logic [7:0]            mem_dout_n;
  logic                  mem_wr_n;
  logic                  mcif_en_n, r_en_n, w_en_n;
  logic [31:0]           mcif_data_n, mclsb_data_n;
  logic                  io_stall;

`ifdef MC_IO_STALL_EN
  assign io_stall = LSBMC_wr && (LSBMC_addr[17:16] == IO_PREFIX) && io_buffer_full;
`else
  assign io_stall = 1'b0;
  logic unused_io_buffer_full;
  assign unused_io_buffer_full = io_buffer_full;
`endif

  // Bytes are shifted in from the top; drop the unused low lanes so the word is zero-extended.
  function automatic logic [31:0] align(input logic [31:0] v, input logic [1:0] l);
    case (l)
      2'd0:    align = {24'b0, v[31:24]};
      2'd1:    align = {16'b0, v[31:16]};
      default: align = v;
    endcase
  endfunction

  always_comb begin
    state_n      = state;
    k_n          = k;
    last_n       = last;
    is_lsb_n     = is_lsb;
    base_n       = base;
    wshift_n     = wshift;
    rbuf_n       = rbuf;
    mem_a_n      = mem_a;
    mem_dout_n   = mem_dout;
    mem_wr_n     = mem_wr;
    mcif_en_n    = 1'b0;
    r_en_n       = 1'b0;
    w_en_n       = 1'b0;
    mcif_data_n  = MCIF_data;
    mclsb_data_n = MCLSB_data;

    case (state)
      IDLE: begin
        if (RoBMC_pre_judge) begin
          if (LSBMC_en && !io_stall) begin
            is_lsb_n = 1'b1;
            base_n   = ADDR_WIDTH'(LSBMC_addr);
            mem_a_n  = ADDR_WIDTH'(LSBMC_addr);
            k_n      = 2'd0;
            rbuf_n   = 32'b0;
            wshift_n = LSBMC_data >> 8;
            case (LSBMC_data_width)
              3'd1:    last_n = 2'd0;
              3'd2:    last_n = 2'd1;
              default: last_n = 2'd3;
            endcase
            if (LSBMC_wr) begin
              state_n    = WRITE;
              mem_dout_n = LSBMC_data[7:0];
              mem_wr_n   = 1'b1;
            end else begin
              state_n = READ;
            end
          end else if (IFMC_en) begin
            is_lsb_n = 1'b0;
            base_n   = ADDR_WIDTH'(IFMC_addr);
            mem_a_n  = ADDR_WIDTH'(IFMC_addr);
            k_n      = 2'd0;
            rbuf_n   = 32'b0;
            last_n   = 2'd3;
            state_n  = READ;
          end
        end
      end

      READ: begin
        if (!RoBMC_pre_judge) begin
          state_n = IDLE;
          mem_a_n = '0;
        end else begin
          rbuf_n = {mem_din, rbuf[31:8]};
          if (k == last) begin
            state_n = DONE;
            mem_a_n = '0;
            if (is_lsb) begin
              r_en_n       = 1'b1;
              mclsb_data_n = align(rbuf_n, last);
            end else begin
              mcif_en_n   = 1'b1;
              mcif_data_n = align(rbuf_n, last);
            end
          end else begin
            k_n     = k + 2'd1;
            mem_a_n = base + ADDR_WIDTH'(k) + ADDR_WIDTH'(1);
          end
        end
      end

      // Stores always run to completion, even across a flush.
      WRITE: begin
        if (k == last) begin
          state_n    = DONE;
          mem_wr_n   = 1'b0;
          mem_a_n    = '0;
          mem_dout_n = 8'b0;
          w_en_n     = 1'b1;
        end else begin
          k_n        = k + 2'd1;
          mem_a_n    = base + ADDR_WIDTH'(k) + ADDR_WIDTH'(1);
          mem_dout_n = wshift[7:0];
          wshift_n   = wshift >> 8;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge Sys_clk or posedge Sys_rst) begin
    if (Sys_rst) begin
      state      <= IDLE;
      k          <= 2'd0;
      last       <= 2'd0;
      is_lsb     <= 1'b0;
      base       <= '0;
      wshift     <= 32'b0;
      rbuf       <= 32'b0;
      mem_a      <= '0;
      mem_dout   <= 8'b0;
      mem_wr     <= 1'b0;
      MCIF_en    <= 1'b0;
      MCLSB_r_en <= 1'b0;
      MCLSB_w_en <= 1'b0;
      MCIF_data  <= 32'b0;
      MCLSB_data <= 32'b0;
    end else if (Sys_rdy) begin
      state      <= state_n;
      k          <= k_n;
      last       <= last_n;
      is_lsb     <= is_lsb_n;
      base       <= base_n;
      wshift     <= wshift_n;
      rbuf       <= rbuf_n;
      mem_a      <= mem_a_n;
      mem_dout   <= mem_dout_n;
      mem_wr     <= mem_wr_n;
      MCIF_en    <= mcif_en_n;
      MCLSB_r_en <= r_en_n;
      MCLSB_w_en <= w_en_n;
      MCIF_data  <= mcif_data_n;
      MCLSB_data <= mclsb_data_n;
    end
  end

endmodule
